// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: start/8 data/odd parity/stop with a stall watchdog,
// followed by a key stage that folds E0/F0 prefixes into single key events.
module ps2_frame_receiver #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       FallingEdge,
    input  logic       PS2Data,
    output logic       Busy,
    output logic [7:0] ScanCode,
    output logic       CodeValid,
    output logic       ParityError,
    output logic       FrameError,
    output logic [7:0] KeyCode,
    output logic       KeyRelease,
    output logic       KeyExtended,
    output logic       KeyValid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             parity_bit;
    logic [CNT_W-1:0] wd;
    logic             ext_pend;
    logic             rel_pend;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // Frame FSM, watchdog and frame-level result pulses.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            shift       <= 8'h00;
            parity_bit  <= 1'b0;
            wd          <= '0;
            Busy        <= 1'b0;
            ScanCode    <= 8'h00;
            CodeValid   <= 1'b0;
            ParityError <= 1'b0;
            FrameError  <= 1'b0;
        end else begin
            CodeValid   <= 1'b0;
            ParityError <= 1'b0;
            FrameError  <= 1'b0;
            if (!Enable) begin
                state   <= IDLE;
                Busy    <= 1'b0;
                bit_cnt <= 3'd0;
                wd      <= '0;
            end else if (state == IDLE) begin
                wd <= '0;
                if (FallingEdge && !PS2Data) begin
                    state   <= DATA;
                    Busy    <= 1'b1;
                    bit_cnt <= 3'd0;
                end
            end else if (FallingEdge) begin
                // An edge always beats a watchdog expiry in the same cycle.
                wd <= '0;
                case (state)
                    DATA: begin
                        shift   <= {PS2Data, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_bit <= PS2Data;
                        state      <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                        if (!PS2Data) begin
                            FrameError <= 1'b1;
                        end else if (odd_parity_ok(shift, parity_bit)) begin
                            ScanCode  <= shift;
                            CodeValid <= 1'b1;
                        end else begin
                            ParityError <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                endcase
            end else if (wd == WD_LAST) begin
                state      <= IDLE;
                Busy       <= 1'b0;
                wd         <= '0;
                FrameError <= 1'b1;
            end else begin
                wd <= wd + CNT_W'(1);
            end
        end
    end

    // Key stage: prefixes accumulate until a plain code completes the event.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ext_pend    <= 1'b0;
            rel_pend    <= 1'b0;
            KeyCode     <= 8'h00;
            KeyRelease  <= 1'b0;
            KeyExtended <= 1'b0;
            KeyValid    <= 1'b0;
        end else begin
            KeyValid <= 1'b0;
            if (CodeValid) begin
                if (ScanCode == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (ScanCode == 8'hF0) begin
                    rel_pend <= 1'b1;
                end else begin
                    KeyCode     <= ScanCode;
                    KeyRelease  <= rel_pend;
                    KeyExtended <= ext_pend;
                    KeyValid    <= 1'b1;
                    ext_pend    <= 1'b0;
                    rel_pend    <= 1'b0;
                end
            end else if (ParityError || FrameError) begin
                ext_pend <= 1'b0;
                rel_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Self-checking bench for ps2_frame_receiver: directed vector table, multi-cycle corner
// sequences, and random frames checked against a transaction-level model.
module tb_ps2_frame_receiver;

    localparam int TO = 40;

    logic       Clock = 1'b0;
    logic       Reset, Enable, FallingEdge, PS2Data;
    logic       Busy, CodeValid, ParityError, FrameError;
    logic [7:0] ScanCode, KeyCode;
    logic       KeyRelease, KeyExtended, KeyValid;

    ps2_frame_receiver #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .FallingEdge(FallingEdge),
        .PS2Data(PS2Data), .Busy(Busy), .ScanCode(ScanCode), .CodeValid(CodeValid),
        .ParityError(ParityError), .FrameError(FrameError), .KeyCode(KeyCode),
        .KeyRelease(KeyRelease), .KeyExtended(KeyExtended), .KeyValid(KeyValid)
    );

    always #5 Clock = ~Clock;

    int tests = 0;
    int fails = 0;
    int pulses = 0;

    // Running count of every output pulse seen.
    always @(negedge Clock)
        pulses <= pulses + int'(CodeValid) + int'(ParityError) + int'(FrameError) + int'(KeyValid);

    typedef struct {
        logic [7:0] d;
        logic       flip;
        logic       stopb;
        logic [2:0] flags;   // {CodeValid, ParityError, FrameError}
        logic [7:0] scan;
        logic       kv;
        logic [7:0] key;
        logic       rel;
        logic       ext;
    } vec_t;

    vec_t vecs[13];

    // Reference model state (transaction level)
    logic [7:0] m_scan, m_key;
    logic       m_rel, m_ext, m_krel, m_kext;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic good_parity(input logic [7:0] d);
        return ~(^d);
    endfunction

    task automatic send_bit(input logic b, input int gap);
        repeat (gap) @(negedge Clock);
        PS2Data     = b;
        FallingEdge = 1'b1;
        @(negedge Clock);
        FallingEdge = 1'b0;
        PS2Data     = 1'($urandom % 2);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip, input logic stopb, input int maxgap);
        send_bit(1'b0, $urandom_range(maxgap, 0));
        for (int i = 0; i < 8; i++) send_bit(d[i], $urandom_range(maxgap, 0));
        send_bit(good_parity(d) ^ flip, $urandom_range(maxgap, 0));
        send_bit(stopb, $urandom_range(maxgap, 0));
    endtask

    // Called on the negedge right after the stop edge was sampled.
    task automatic expect_frame(input string tag, input logic [2:0] flags, input logic [7:0] scan,
                                input logic kv, input logic [7:0] key, input logic rel, input logic ext);
        check({tag, " result"}, {29'd0, CodeValid, ParityError, FrameError}, {29'd0, flags});
        check({tag, " ScanCode"}, {24'd0, ScanCode}, {24'd0, scan});
        check({tag, " Busy"}, {31'd0, Busy}, 32'd0);
        @(negedge Clock);
        check({tag, " pulse width"}, {29'd0, CodeValid, ParityError, FrameError}, 32'd0);
        check({tag, " key flags"}, {29'd0, KeyValid, KeyRelease, KeyExtended}, {29'd0, kv, rel, ext});
        check({tag, " KeyCode"}, {24'd0, KeyCode}, {24'd0, key});
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
    endtask

    initial begin
        int cnt, p0;
        logic [7:0] d;
        logic flip, stopb, kv;
        logic [2:0] flags;

        vecs[0]  = '{8'h1C, 1'b0, 1'b1, 3'b100, 8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0};
        vecs[1]  = '{8'hF0, 1'b0, 1'b1, 3'b100, 8'hF0, 1'b0, 8'h1C, 1'b0, 1'b0};
        vecs[2]  = '{8'h1C, 1'b0, 1'b1, 3'b100, 8'h1C, 1'b1, 8'h1C, 1'b1, 1'b0};
        vecs[3]  = '{8'hE0, 1'b0, 1'b1, 3'b100, 8'hE0, 1'b0, 8'h1C, 1'b1, 1'b0};
        vecs[4]  = '{8'hF0, 1'b0, 1'b1, 3'b100, 8'hF0, 1'b0, 8'h1C, 1'b1, 1'b0};
        vecs[5]  = '{8'h75, 1'b0, 1'b1, 3'b100, 8'h75, 1'b1, 8'h75, 1'b1, 1'b1};
        vecs[6]  = '{8'h1C, 1'b1, 1'b1, 3'b010, 8'h75, 1'b0, 8'h75, 1'b1, 1'b1};
        vecs[7]  = '{8'hF0, 1'b0, 1'b1, 3'b100, 8'hF0, 1'b0, 8'h75, 1'b1, 1'b1};
        vecs[8]  = '{8'h33, 1'b1, 1'b1, 3'b010, 8'hF0, 1'b0, 8'h75, 1'b1, 1'b1};
        vecs[9]  = '{8'h1C, 1'b0, 1'b1, 3'b100, 8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0};
        vecs[10] = '{8'hE0, 1'b0, 1'b1, 3'b100, 8'hE0, 1'b0, 8'h1C, 1'b0, 1'b0};
        vecs[11] = '{8'h1C, 1'b0, 1'b0, 3'b001, 8'hE0, 1'b0, 8'h1C, 1'b0, 1'b0};
        vecs[12] = '{8'h6B, 1'b0, 1'b1, 3'b100, 8'h6B, 1'b1, 8'h6B, 1'b0, 1'b0};

        Reset = 1'b1; Enable = 1'b1; FallingEdge = 1'b0; PS2Data = 1'b1;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        check("reset Busy/pulses", {28'd0, Busy, CodeValid, ParityError, FrameError}, 32'd0);
        check("reset ScanCode", {24'd0, ScanCode}, 32'd0);
        check("reset key outputs", {21'd0, KeyCode, KeyValid, KeyRelease, KeyExtended}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            send_frame(vecs[i].d, vecs[i].flip, vecs[i].stopb, 3);
            expect_frame($sformatf("vec%0d", i), vecs[i].flags, vecs[i].scan,
                         vecs[i].kv, vecs[i].key, vecs[i].rel, vecs[i].ext);
        end

        // Idle edge with data high is not a start bit
        #1 p0 = pulses;
        send_bit(1'b1, 0);
        check("idle high edge Busy", {31'd0, Busy}, 32'd0);
        repeat (3) @(negedge Clock);
        #1 check("idle high edge pulses", pulses, p0);

        // Watchdog: start + 3 bits then silence
        @(negedge Clock);
        send_bit(1'b0, 1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, $urandom_range(3, 0));
        check("timeout Busy before", {31'd0, Busy}, 32'd1);
        cnt = 0;
        while (!FrameError && cnt < TO + 20) begin
            @(negedge Clock);
            cnt++;
        end
        check("timeout latency", cnt, TO);
        check("timeout Busy after", {31'd0, Busy}, 32'd0);
        @(negedge Clock);
        check("timeout pulse width", {31'd0, FrameError}, 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1, 2);
        expect_frame("after timeout", 3'b100, 8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0);

        // Reset after 4 data bits
        send_bit(1'b0, 1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1);
        #1 p0 = pulses;
        do_reset();
        check("mid reset Busy", {31'd0, Busy}, 32'd0);
        check("mid reset ScanCode", {24'd0, ScanCode}, 32'd0);
        repeat (2) @(negedge Clock);
        #1 check("mid reset pulses", pulses, p0);
        send_frame(8'h29, 1'b0, 1'b1, 2);
        expect_frame("after reset", 3'b100, 8'h29, 1'b1, 8'h29, 1'b0, 1'b0);

        // Enable drop mid-frame keeps the pending F0
        send_frame(8'hF0, 1'b0, 1'b1, 2);
        expect_frame("F0 before disable", 3'b100, 8'hF0, 1'b0, 8'h29, 1'b0, 1'b0);
        send_bit(1'b0, 1);
        send_bit(1'b1, 1);
        send_bit(1'b0, 1);
        #1 p0 = pulses;
        Enable = 1'b0;
        @(negedge Clock);
        check("disable Busy", {31'd0, Busy}, 32'd0);
        repeat (TO + 5) @(negedge Clock);
        #1 check("disable no pulses", pulses, p0);
        Enable = 1'b1;
        send_frame(8'h1C, 1'b0, 1'b1, 2);
        expect_frame("after enable", 3'b100, 8'h1C, 1'b1, 8'h1C, 1'b1, 1'b0);

        // Random frames against the model
        do_reset();
        m_scan = 8'h00; m_key = 8'h00; m_rel = 1'b0; m_ext = 1'b0; m_krel = 1'b0; m_kext = 1'b0;
        for (int n = 0; n < 80; n++) begin
            d = 8'($urandom);
            case ($urandom % 6)
                0: d = 8'hE0;
                1: d = 8'hF0;
                default: ;
            endcase
            flip  = ($urandom % 8) == 0;
            stopb = ($urandom % 8) != 0;
            kv    = 1'b0;
            if (!stopb) begin
                flags = 3'b001; m_rel = 1'b0; m_ext = 1'b0;
            end else if (flip) begin
                flags = 3'b010; m_rel = 1'b0; m_ext = 1'b0;
            end else begin
                flags  = 3'b100;
                m_scan = d;
                if (d == 8'hE0) m_ext = 1'b1;
                else if (d == 8'hF0) m_rel = 1'b1;
                else begin
                    kv = 1'b1; m_key = d; m_krel = m_rel; m_kext = m_ext;
                    m_rel = 1'b0; m_ext = 1'b0;
                end
            end
            if (($urandom % 5) == 0) send_bit(1'b1, $urandom_range(3, 0));
            send_frame(d, flip, stopb, 4);
            expect_frame($sformatf("rand%0d", n), flags, m_scan, kv, m_key, m_krel, m_kext);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
